// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single divider S = A / B: restoring mantissa division, Q_BITS quotient bits per cycle.
// `define ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fp32_div_seq #(
  parameter int Q_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S,
  output logic        busy
);

  localparam int ITERS = 26 / Q_BITS;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  state_t state, state_nx;

  logic [24:0]       rem_q;
  logic [23:0]       dvs_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              sgn_q;
  logic signed [9:0] exp_q;
  logic [31:0]       s_q;

  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sg, special;
  logic [31:0] special_res;

  assign ea     = A[30:23];
  assign eb     = B[30:23];
  assign a_nan  = (ea == 8'hFF) && (A[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (B[22:0] != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (A[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (B[22:0] == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign sg     = A[31] ^ B[31];
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    special_res = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      special_res = 32'h7FFF_FFFF;
    else if (a_inf || b_zero)
      special_res = {sg, 31'h7F80_0000};
  end

  // One restoring step per quotient bit: compare, conditionally subtract, shift.
  logic [24:0] rem_nx, r;
  logic [25:0] quo_nx, qv;
  always_comb begin
    r  = rem_q;
    qv = quo_q;
    for (int i = 0; i < Q_BITS; i++) begin
      if (r >= {1'b0, dvs_q}) begin
        r  = (r - {1'b0, dvs_q}) << 1;
        qv = {qv[24:0], 1'b1};
      end else begin
        r  = r << 1;
        qv = {qv[24:0], 1'b0};
      end
    end
    rem_nx = r;
    quo_nx = qv;
  end

  // Normalise: quotient lies in [2^24, 2^26); keep 24 significant bits incl. hidden one.
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic              inc;
  logic signed [9:0] e_n;
  logic [22:0]       frac;
  logic [31:0]       norm_res;
  always_comb begin
    mant = quo_q[25] ? quo_q[25:2] : quo_q[24:1];
    e_n  = quo_q[25] ? exp_q : exp_q - 10'sd1;
`ifdef ROUND_NEAREST_EN
    if (quo_q[25])
      inc = quo_q[1] & (quo_q[0] | (rem_q != 25'd0) | mant[0]);
    else
      inc = quo_q[0] & ((rem_q != 25'd0) | mant[0]);
`else
    inc = 1'b0;
`endif
    mant_r = {1'b0, mant} + {24'd0, inc};
    frac   = mant_r[22:0];
    if (mant_r[24]) begin
      frac = mant_r[23:1];
      e_n  = e_n + 10'sd1;
    end
    if (e_n >= 10'sd255)
      norm_res = {sgn_q, 31'h7F80_0000};
    else if (e_n <= 10'sd0)
      norm_res = 32'h0000_0000;
    else
      norm_res = {sgn_q, e_n[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = special ? DONE : DIV;
      end
      DIV:  if (cnt_q == 5'(ITERS - 1)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      exp_q <= '0;
      s_q   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn_q <= sg;
          exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          rem_q <= {2'b01, A[22:0]};
          dvs_q <= {1'b1, B[22:0]};
          quo_q <= '0;
          cnt_q <= '0;
          if (special) s_q <= special_res;
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: s_q <= norm_res;
        default: ;
      endcase
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: directed vector table, handshake/reset sequences, randomized operands vs. model.
module tb_fp32_div_seq;
  localparam int QB   = 1;
  localparam int NLAT = 26 / QB + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] S;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp32_div_seq #(.Q_BITS(QB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .S(S), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: returns {is_special, result}, derived from exact integer quotient.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic       sg, an, bn, ai, bi, az, bz;
    longint     ma, mb, num, q, r, m, lost, half;
    int         e, sh;
    ea = a[30:23]; eb = b[30:23]; sg = a[31] ^ b[31];
    an = (ea == 8'hFF) && (a[22:0] != 0); bn = (eb == 8'hFF) && (b[22:0] != 0);
    ai = (ea == 8'hFF) && (a[22:0] == 0); bi = (eb == 8'hFF) && (b[22:0] == 0);
    az = (ea == 0); bz = (eb == 0);
    if (an || bn || (ai && bi) || (az && bz)) return {1'b1, 32'h7FFFFFFF};
    if (ai || bz) return {1'b1, sg, 31'h7F800000};
    if (az || bi) return {1'b1, 32'h0};
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    num = ma * 64'd33554432;
    q = num / mb;
    r = num % mb;
    e = int'(ea) - int'(eb) + 127;
    if (q >= 64'd33554432) sh = 2;
    else begin sh = 1; e = e - 1; end
    m = q >> sh;
    lost = q - (m << sh);
    half = 64'd1 << (sh - 1);
`ifdef ROUND_NEAREST_EN
    if (lost > half || (lost == half && r != 0) || (lost == half && r == 0 && m[0])) m = m + 1;
`else
    if (lost < 0 || r < 0 || half < 0) m = 0;
`endif
    if (m == 64'd16777216) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {1'b0, sg, 31'h7F800000};
    if (e <= 0) return 33'h0;
    return {1'b0, sg, e[7:0], m[22:0]};
  endfunction

  // Launch one operation, measure edges from accept to out_valid, then complete the handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output int lat);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    s = S;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] s, held, ra, rb;
  logic [32:0] ref_v;
  int          lat;

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, NLAT, "6/2"};
`ifdef ROUND_NEAREST_EN
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NLAT, "1/3"};
`else
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, NLAT, "1/3"};
`endif
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1,    "1/0"};
    vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1,    "-1/0"};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1,    "0/0"};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FFFFFFF, 1,    "inf/inf"};
    vecs[6]  = '{32'h7FC00000, 32'h40000000, 32'h7FFFFFFF, 1,    "nan/2"};
    vecs[7]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 1,    "2/inf"};
    vecs[8]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, NLAT, "overflow"};
    vecs[9]  = '{32'h00800000, 32'h7F000000, 32'h00000000, NLAT, "underflow"};
    vecs[10] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1,    "denorm/1"};
    vecs[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, NLAT, "-6/2"};
    vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, NLAT, "1/1"};

    #12;
    check("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0} | {S != 0, 31'd0}, 32'h8);
    check("reset_s", S, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, s, lat);
      check({vecs[i].name, "_s"}, s, vecs[i].s);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held, further operands ignored, in_ready low.
    A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp_lat", 32'(lat), 32'(NLAT));
    held = S;
    check("bp_first", held, 32'h40400000);
    A = 32'h3F800000; B = 32'h00000000; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, busy, S[28:0]}, {3'b101, held[28:0]});
      check("bp_hold_s", S, 32'h40400000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'h4);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept", {31'd0, busy}, 32'h0);

    // Reset in the middle of the division.
    A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("mid_busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check("mid_rst_s", S, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'h40C00000, 32'h40000000, s, lat);
    check("post_rst_s", s, 32'h40400000);
    check("post_rst_lat", 32'(lat), 32'(NLAT));

    // Randomized operands against the model.
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 3 != 0) begin
        ra[30:23] = 8'(110 + $urandom_range(0, 35));
        rb[30:23] = 8'(110 + $urandom_range(0, 35));
      end
      if (k % 7 == 0) rb[22:0] = 23'h7FFFFF;
      ref_v = model(ra, rb);
      do_op(ra, rb, s, lat);
      check($sformatf("rand%0d_s a=%h b=%h", k, ra, rb), s, ref_v[31:0]);
      check($sformatf("rand%0d_lat", k), 32'(lat), ref_v[32] ? 32'd1 : 32'(NLAT));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
